// File: rtl/keygen_sequencer_pkg.sv
// Shared types and constants for the RSA key-generation sequencer and its prime fetcher.
package keygen_sequencer_pkg;

    localparam int unsigned KG_SIZE    = 55;
    localparam int unsigned KG_WIDE    = 2 * KG_SIZE;
    localparam int unsigned KG_E_TRIES = 16;
    localparam int unsigned KG_ROUNDS  = 4;

    // Clamped so a degenerate count range still yields a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n_vals);
        return (n_vals <= 1) ? 1 : $clog2(n_vals);
    endfunction

    localparam int unsigned KG_ECNT_W = cnt_width(KG_E_TRIES + 1);
    localparam int unsigned KG_RCNT_W = cnt_width(KG_ROUNDS);

    typedef enum logic [3:0] {
        StIdle,
        StGetP,
        StGetQ,
        StMulN,
        StMulL,
        StGetE,
        StChkE,
        StInv,
        StLoad,
        StDone,
        StFail
    } kg_state_e;

    typedef enum logic {
        FetchIdle,
        FetchReq
    } fetch_state_e;

endpackage

// File: rtl/keygen_sequencer_if.sv
// Handshake bundle between the sequencer and its prime source, multiplier, inverse unit
// and output stage.
interface keygen_sequencer_if #(
    parameter int unsigned SIZE = 55
);
    logic              st;
    logic              busy;
    logic              done;
    logic              fail;
    logic              prime_req;
    logic              prime_ack;
    logic [SIZE-1:0]   prime_val;
    logic              mul_start;
    logic [SIZE-1:0]   mul_a;
    logic [SIZE-1:0]   mul_b;
    logic              mul_done;
    logic [2*SIZE-1:0] mul_f;
    logic              inv_start;
    logic [SIZE-1:0]   inv_e;
    logic [2*SIZE-1:0] inv_m;
    logic              inv_done;
    logic              inv_ok;
    logic [2*SIZE-1:0] inv_d;
    logic              Load;
    logic [2*SIZE-1:0] n;
    logic [SIZE-1:0]   e;
    logic [2*SIZE-1:0] d;

    modport master (
        input  st, prime_ack, prime_val, mul_done, mul_f, inv_done, inv_ok, inv_d,
        output busy, done, fail, prime_req, mul_start, mul_a, mul_b, inv_start, inv_e, inv_m,
               Load, n, e, d
    );

    modport slave (
        output st, prime_ack, prime_val, mul_done, mul_f, inv_done, inv_ok, inv_d,
        input  busy, done, fail, prime_req, mul_start, mul_a, mul_b, inv_start, inv_e, inv_m,
               Load, n, e, d
    );
endinterface

// File: rtl/keygen_sequencer_prime_fetch.sv
// Request/ack handshake with the prime source; o_vld pulses the cycle after the ack with the
// captured value on o_val.
module keygen_sequencer_prime_fetch
    import keygen_sequencer_pkg::*;
#(
    parameter int unsigned SIZE = KG_SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_go,
    input  logic            i_ack,
    input  logic [SIZE-1:0] i_val,
    output logic            o_req,
    output logic            o_vld,
    output logic [SIZE-1:0] o_val
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic            r_vld;
    logic [SIZE-1:0] r_val;
    logic            w_capture;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            FetchIdle: begin
                if (i_go) w_state_next = FetchReq;
            end
            FetchReq: begin
                if (i_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = FetchIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FetchIdle;
            r_vld   <= 1'b0;
            r_val   <= '0;
        end else begin
            r_state <= w_state_next;
            r_vld   <= w_capture;
            if (w_capture) r_val <= i_val;
        end
    end

    assign o_req = (r_state == FetchReq);
    assign o_vld = r_vld;
    assign o_val = r_val;

endmodule

// File: rtl/keygen_sequencer.sv
// RSA key-generation control: draws p, q and e, drives the shared multiplier and the
// modular-inverse unit, retries on rejection and presents n, e, d with a Load strobe.
module keygen_sequencer
    import keygen_sequencer_pkg::*;
#(
    parameter int unsigned SIZE    = KG_SIZE,
    parameter int unsigned E_TRIES = KG_E_TRIES,
    parameter int unsigned ROUNDS  = KG_ROUNDS
) (
    input logic               clk,
    input logic               reset,
    keygen_sequencer_if.master bus
);

    localparam int unsigned WIDE = 2 * SIZE;
    localparam int unsigned ECW  = cnt_width(E_TRIES + 1);
    localparam int unsigned RCW  = cnt_width(ROUNDS);
    localparam logic [ECW-1:0] ECNT_MAX  = ECW'(E_TRIES);
    localparam logic [RCW-1:0] RCNT_LAST = RCW'(ROUNDS - 1);

    kg_state_e       r_state;
    kg_state_e       w_state_next;
    logic [SIZE-1:0] r_p, r_q, r_ecand, r_mul_a, r_mul_b, r_e;
    logic [WIDE-1:0] r_nval, r_l, r_n, r_d;
    logic [ECW-1:0]  r_ecnt;
    logic [RCW-1:0]  r_rcnt;
    logic            r_mul_start, r_inv_start, r_issued;
    logic            r_busy, r_done, r_fail, r_load;

    logic            w_go, w_fetch_req, w_fetch_vld, w_val_ok;
    logic [SIZE-1:0] w_fetch_val;
    logic            w_mul_fire, w_inv_fire, w_mul_evt, w_inv_evt;
    logic            w_reject, w_new_round, w_begin, w_next_idle;

    keygen_sequencer_prime_fetch #(
        .SIZE (SIZE)
    ) u_prime_fetch (
        .clk   (clk),
        .reset (reset),
        .i_go  (w_go),
        .i_ack (bus.prime_ack),
        .i_val (bus.prime_val),
        .o_req (w_fetch_req),
        .o_vld (w_fetch_vld),
        .o_val (w_fetch_val)
    );

    // A done that coincides with its own start strobe is not a completion.
    assign w_mul_evt = ((r_state == StMulN) || (r_state == StMulL)) && r_issued &&
                       !r_mul_start && bus.mul_done;
    assign w_inv_evt = (r_state == StInv) && r_issued && !r_inv_start && bus.inv_done;

    always_comb begin
        w_state_next = r_state;
        w_go         = 1'b0;
        w_val_ok     = 1'b1;
        w_mul_fire   = 1'b0;
        w_inv_fire   = 1'b0;
        w_reject     = 1'b0;
        w_new_round  = 1'b0;
        w_begin      = 1'b0;
        unique case (r_state)
            StIdle, StDone, StFail: begin
                if (bus.st) begin
                    w_begin      = 1'b1;
                    w_state_next = StGetP;
                end
            end
            StGetP: begin
                w_val_ok = (w_fetch_val >= SIZE'(3));
                w_go     = !w_fetch_req && !(w_fetch_vld && w_val_ok);
                if (w_fetch_vld && w_val_ok) w_state_next = StGetQ;
            end
            StGetQ: begin
                w_val_ok = (w_fetch_val >= SIZE'(3)) && (w_fetch_val != r_p);
                w_go     = !w_fetch_req && !(w_fetch_vld && w_val_ok);
                if (w_fetch_vld && w_val_ok) w_state_next = StMulN;
            end
            StMulN: begin
                if (!r_issued) w_mul_fire = 1'b1;
                else if (w_mul_evt) w_state_next = StMulL;
            end
            StMulL: begin
                if (!r_issued) w_mul_fire = 1'b1;
                else if (w_mul_evt) w_state_next = StGetE;
            end
            StGetE: begin
                w_go = !w_fetch_req && !w_fetch_vld;
                if (w_fetch_vld) w_state_next = StChkE;
            end
            StChkE: begin
                if ((r_ecand < SIZE'(3)) || ({{SIZE{1'b0}}, r_ecand} >= r_l)) w_reject = 1'b1;
                else w_state_next = StInv;
            end
            StInv: begin
                if (!r_issued) w_inv_fire = 1'b1;
                else if (w_inv_evt) begin
                    if (bus.inv_ok) w_state_next = StLoad;
                    else w_reject = 1'b1;
                end
            end
            StLoad:  w_state_next = StDone;
            default: w_state_next = StIdle;
        endcase
        if (w_reject) begin
            if (r_ecnt < ECNT_MAX) begin
                w_state_next = StGetE;
            end else if (r_rcnt < RCNT_LAST) begin
                w_new_round  = 1'b1;
                w_state_next = StGetP;
            end else begin
                w_state_next = StFail;
            end
        end
    end

    assign w_next_idle = (w_state_next == StIdle) || (w_state_next == StDone) ||
                         (w_state_next == StFail);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_p         <= '0;
            r_q         <= '0;
            r_ecand     <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_nval      <= '0;
            r_l         <= '0;
            r_n         <= '0;
            r_e         <= '0;
            r_d         <= '0;
            r_ecnt      <= '0;
            r_rcnt      <= '0;
            r_mul_start <= 1'b0;
            r_inv_start <= 1'b0;
            r_issued    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_load      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mul_start <= w_mul_fire;
            r_inv_start <= w_inv_fire;
            if (w_mul_fire || w_inv_fire) r_issued <= 1'b1;
            else if (w_state_next != r_state) r_issued <= 1'b0;
            if (w_mul_fire) begin
                r_mul_a <= (r_state == StMulN) ? r_p : (r_p - SIZE'(1));
                r_mul_b <= (r_state == StMulN) ? r_q : (r_q - SIZE'(1));
            end
            if (w_fetch_vld && (r_state == StGetP)) r_p <= w_fetch_val;
            if (w_fetch_vld && (r_state == StGetQ)) r_q <= w_fetch_val;
            if (w_fetch_vld && (r_state == StGetE)) begin
                r_ecand <= w_fetch_val;
                r_ecnt  <= r_ecnt + ECW'(1);
            end
            if (w_mul_evt && (r_state == StMulN)) r_nval <= bus.mul_f;
            if (w_mul_evt && (r_state == StMulL)) r_l <= bus.mul_f;
            if (w_begin) begin
                r_ecnt <= '0;
                r_rcnt <= '0;
            end
            if (w_new_round) begin
                r_ecnt <= '0;
                r_rcnt <= r_rcnt + RCW'(1);
            end
            r_busy <= !w_next_idle;
            r_done <= (w_state_next == StDone);
            r_fail <= (w_state_next == StFail);
            r_load <= (w_state_next == StLoad);
            // LOAD is entered only on the inverse completion edge, so inv_d is live here.
            if (w_state_next == StLoad) begin
                r_n <= r_nval;
                r_e <= r_ecand;
                r_d <= bus.inv_d;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.fail      = r_fail;
    assign bus.prime_req = w_fetch_req;
    assign bus.mul_start = r_mul_start;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.inv_start = r_inv_start;
    assign bus.inv_e     = r_ecand;
    assign bus.inv_m     = r_l;
    assign bus.Load      = r_load;
    assign bus.n         = r_n;
    assign bus.e         = r_e;
    assign bus.d         = r_d;

endmodule

// File: tb/tb_keygen_sequencer.sv
// Directed bench for keygen_sequencer: behavioural prime source, multiplier and inverse unit
// feed two instances (default and a small-retry variant selected by sel).
module tb_keygen_sequencer;

    localparam int unsigned SZ = 55;
    localparam int unsigned WD = 2 * SZ;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic st    = 1'b0;
    logic sel   = 1'b0;
    logic env_clr = 1'b1;

    logic          prime_ack = 1'b0;
    logic [SZ-1:0] prime_val = '0;
    logic          mul_done  = 1'b0;
    logic [WD-1:0] mul_f     = '0;
    logic          inv_done  = 1'b0;
    logic          inv_ok    = 1'b0;
    logic [WD-1:0] inv_d     = '0;

    always #5 clk = ~clk;

    keygen_sequencer_if #(.SIZE(SZ)) if_a ();
    keygen_sequencer_if #(.SIZE(SZ)) if_b ();

    keygen_sequencer #(
        .SIZE (SZ)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.master)
    );

    keygen_sequencer #(
        .SIZE    (SZ),
        .E_TRIES (2),
        .ROUNDS  (2)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.master)
    );

    assign if_a.st = st & ~sel;
    assign if_b.st = st & sel;
    assign if_a.prime_ack = prime_ack;
    assign if_b.prime_ack = prime_ack;
    assign if_a.prime_val = prime_val;
    assign if_b.prime_val = prime_val;
    assign if_a.mul_done  = mul_done;
    assign if_b.mul_done  = mul_done;
    assign if_a.mul_f     = mul_f;
    assign if_b.mul_f     = mul_f;
    assign if_a.inv_done  = inv_done;
    assign if_b.inv_done  = inv_done;
    assign if_a.inv_ok    = inv_ok;
    assign if_b.inv_ok    = inv_ok;
    assign if_a.inv_d     = inv_d;
    assign if_b.inv_d     = inv_d;

    logic          w_busy, w_done, w_fail, w_prime_req, w_mul_start, w_inv_start, w_load;
    logic [SZ-1:0] w_mul_a, w_mul_b, w_inv_e, w_e;
    logic [WD-1:0] w_n, w_d;

    assign w_busy      = sel ? if_b.busy      : if_a.busy;
    assign w_done      = sel ? if_b.done      : if_a.done;
    assign w_fail      = sel ? if_b.fail      : if_a.fail;
    assign w_prime_req = sel ? if_b.prime_req : if_a.prime_req;
    assign w_mul_start = sel ? if_b.mul_start : if_a.mul_start;
    assign w_inv_start = sel ? if_b.inv_start : if_a.inv_start;
    assign w_load      = sel ? if_b.Load      : if_a.Load;
    assign w_mul_a     = sel ? if_b.mul_a     : if_a.mul_a;
    assign w_mul_b     = sel ? if_b.mul_b     : if_a.mul_b;
    assign w_inv_e     = sel ? if_b.inv_e     : if_a.inv_e;
    assign w_e         = sel ? if_b.e         : if_a.e;
    assign w_n         = sel ? if_b.n         : if_a.n;
    assign w_d         = sel ? if_b.d         : if_a.d;

    // Scenario settings, written only by the test tasks.
    logic [SZ-1:0] prime_tab [16];
    int            prime_cnt  = 0;
    int            mul_lat    = 3;
    int            inv_lat    = 3;
    bit            early_mode = 1'b0;
    logic [SZ-1:0] inv_ok_e   = '0;
    logic [WD-1:0] inv_ok_d   = '0;

    // Environment observations, written only by the responder.
    int            prime_idx, n_acks, n_mul, n_inv, n_load, mul_cd, inv_cd;
    logic [SZ-1:0] mul_a_log [8];
    logic [SZ-1:0] mul_b_log [8];
    int            mul_ack_snap [8];
    logic [SZ-1:0] inv_e_log [8];
    logic [WD-1:0] mul_op;
    logic [SZ-1:0] inv_cur;

    int checks   = 0;
    int failures = 0;

    always @(negedge clk) begin
        if (env_clr) begin
            prime_idx = 0;
            n_acks    = 0;
            n_mul     = 0;
            n_inv     = 0;
            n_load    = 0;
            mul_cd    = 0;
            inv_cd    = 0;
            prime_ack = 1'b0;
            mul_done  = 1'b0;
            inv_done  = 1'b0;
            inv_ok    = 1'b0;
        end else begin
            if (prime_ack) begin
                prime_ack = 1'b0;
            end else if (w_prime_req && prime_idx < prime_cnt) begin
                prime_ack = 1'b1;
                prime_val = prime_tab[prime_idx];
                prime_idx++;
                n_acks++;
            end
            mul_done = 1'b0;
            if (w_mul_start) begin
                if (n_mul < 8) begin
                    mul_a_log[n_mul]    = w_mul_a;
                    mul_b_log[n_mul]    = w_mul_b;
                    mul_ack_snap[n_mul] = n_acks;
                end
                n_mul++;
                mul_op = WD'(w_mul_a) * WD'(w_mul_b);
                mul_cd = mul_lat;
                if (early_mode && n_mul == 1) begin
                    mul_done = 1'b1;
                    mul_f    = '1;
                end
            end else if (mul_cd > 0) begin
                mul_cd--;
                if (mul_cd == 0) begin
                    mul_done = 1'b1;
                    mul_f    = mul_op;
                end
            end
            inv_done = 1'b0;
            inv_ok   = 1'b0;
            if (w_inv_start) begin
                if (n_inv < 8) inv_e_log[n_inv] = w_inv_e;
                n_inv++;
                inv_cur = w_inv_e;
                inv_cd  = inv_lat;
            end else if (inv_cd > 0) begin
                inv_cd--;
                if (inv_cd == 0) begin
                    inv_done = 1'b1;
                    inv_ok   = (inv_cur == inv_ok_e);
                    inv_d    = inv_ok ? inv_ok_d : '0;
                end
            end
            if (w_load) n_load++;
        end
    end

    task automatic do_reset();
        reset   = 1'b1;
        st      = 1'b0;
        env_clr = 1'b1;
        prime_cnt  = 0;
        mul_lat    = 3;
        inv_lat    = 3;
        early_mode = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        env_clr = 1'b0;
    endtask

    task automatic push_prime(input longint v);
        prime_tab[prime_cnt] = SZ'(v);
        prime_cnt++;
    endtask

    task automatic start_run();
        @(negedge clk);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
    endtask

    task automatic wait_end(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (w_done || w_fail) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({w_busy, w_done, w_fail, w_prime_req, w_mul_start, w_inv_start, w_load} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {w_busy, w_done, w_fail, w_prime_req, w_mul_start, w_inv_start, w_load});
        end
        checks++;
        if (w_n !== '0 || w_e !== '0 || w_d !== '0) begin
            failures++;
            $display("FAIL reset_ned: got n=%0d e=%0d d=%0d want 0", w_n, w_e, w_d);
        end
        checks++;
        if (w_mul_a !== '0 || w_mul_b !== '0) begin
            failures++;
            $display("FAIL reset_mul_ops: got a=%0d b=%0d want 0", w_mul_a, w_mul_b);
        end
    endtask

    task automatic test_nominal();
        bit seen = 1'b0;
        do_reset();
        push_prime(61); push_prime(53); push_prime(17);
        inv_ok_e = SZ'(17);
        inv_ok_d = WD'(2753);
        start_run();
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (w_load) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL nom_load_seen: got no Load want Load within 500 cycles");
        end
        checks++;
        if (w_n !== WD'(3233)) begin
            failures++;
            $display("FAIL nom_n: got %0d want 3233", w_n);
        end
        checks++;
        if (w_e !== SZ'(17)) begin
            failures++;
            $display("FAIL nom_e: got %0d want 17", w_e);
        end
        checks++;
        if (w_d !== WD'(2753)) begin
            failures++;
            $display("FAIL nom_d: got %0d want 2753", w_d);
        end
        @(negedge clk);
        checks++;
        if (w_done !== 1'b1 || w_busy !== 1'b0 || w_load !== 1'b0) begin
            failures++;
            $display("FAIL nom_done_next: got done=%b busy=%b load=%b want 1 0 0",
                     w_done, w_busy, w_load);
        end
        checks++;
        if (mul_a_log[0] !== SZ'(61) || mul_b_log[0] !== SZ'(53)) begin
            failures++;
            $display("FAIL nom_mul0: got %0d*%0d want 61*53", mul_a_log[0], mul_b_log[0]);
        end
        checks++;
        if (mul_a_log[1] !== SZ'(60) || mul_b_log[1] !== SZ'(52)) begin
            failures++;
            $display("FAIL nom_mul1: got %0d*%0d want 60*52", mul_a_log[1], mul_b_log[1]);
        end
        checks++;
        if (n_mul != 2 || n_load != 1) begin
            failures++;
            $display("FAIL nom_counts: got mul=%0d load=%0d want 2 1", n_mul, n_load);
        end
    endtask

    task automatic test_q_eq_p();
        bit to;
        do_reset();
        push_prime(61); push_prime(61); push_prime(53); push_prime(17);
        inv_ok_e = SZ'(17);
        inv_ok_d = WD'(2753);
        start_run();
        wait_end(800, to);
        checks++;
        if (to || w_done !== 1'b1) begin
            failures++;
            $display("FAIL qp_done: got timeout=%0d done=%b want 0 1", to, w_done);
        end
        checks++;
        if (w_n !== WD'(3233)) begin
            failures++;
            $display("FAIL qp_n: got %0d want 3233", w_n);
        end
        checks++;
        if (mul_ack_snap[0] != 3 || mul_b_log[0] !== SZ'(53)) begin
            failures++;
            $display("FAIL qp_acks_before_mul: got acks=%0d b=%0d want 3 53",
                     mul_ack_snap[0], mul_b_log[0]);
        end
        checks++;
        if (n_acks != 4) begin
            failures++;
            $display("FAIL qp_total_acks: got %0d want 4", n_acks);
        end
    endtask

    task automatic test_e_reject();
        bit to;
        do_reset();
        push_prime(61); push_prime(53);
        push_prime(3120); push_prime(2); push_prime(13); push_prime(17);
        inv_ok_e = SZ'(17);
        inv_ok_d = WD'(2753);
        start_run();
        wait_end(1500, to);
        checks++;
        if (to || w_done !== 1'b1) begin
            failures++;
            $display("FAIL erej_done: got timeout=%0d done=%b want 0 1", to, w_done);
        end
        checks++;
        if (n_acks != 6) begin
            failures++;
            $display("FAIL erej_acks: got %0d want 6", n_acks);
        end
        checks++;
        if (n_inv != 2) begin
            failures++;
            $display("FAIL erej_inv_count: got %0d want 2", n_inv);
        end
        checks++;
        if (inv_e_log[0] !== SZ'(13) || inv_e_log[1] !== SZ'(17)) begin
            failures++;
            $display("FAIL erej_inv_e: got %0d,%0d want 13,17", inv_e_log[0], inv_e_log[1]);
        end
        checks++;
        if (w_e !== SZ'(17) || w_d !== WD'(2753)) begin
            failures++;
            $display("FAIL erej_ed: got e=%0d d=%0d want 17 2753", w_e, w_d);
        end
    endtask

    task automatic test_exhaustion();
        bit to;
        sel = 1'b1;
        do_reset();
        push_prime(61); push_prime(53); push_prime(17); push_prime(7);
        push_prime(61); push_prime(53); push_prime(17); push_prime(7);
        inv_ok_e = '0;
        start_run();
        wait_end(3000, to);
        checks++;
        if (to || w_fail !== 1'b1 || w_done !== 1'b0 || w_busy !== 1'b0) begin
            failures++;
            $display("FAIL exh_fail: got timeout=%0d fail=%b done=%b busy=%b want 0 1 0 0",
                     to, w_fail, w_done, w_busy);
        end
        checks++;
        if (n_inv != 4) begin
            failures++;
            $display("FAIL exh_rejections: got %0d want 4", n_inv);
        end
        checks++;
        if (n_mul != 4 || n_acks != 8) begin
            failures++;
            $display("FAIL exh_rounds: got mul=%0d acks=%0d want 4 8", n_mul, n_acks);
        end
        checks++;
        if (n_load != 0) begin
            failures++;
            $display("FAIL exh_no_load: got %0d want 0", n_load);
        end
        checks++;
        if (w_n !== '0 || w_e !== '0 || w_d !== '0) begin
            failures++;
            $display("FAIL exh_ned_zero: got n=%0d e=%0d d=%0d want 0", w_n, w_e, w_d);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_inv();
        bit seen = 1'b0;
        do_reset();
        push_prime(61); push_prime(53); push_prime(17);
        inv_ok_e = SZ'(17);
        inv_ok_d = WD'(2753);
        start_run();
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (w_inv_start) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rmi_inv_start: got none want inv_start within 500 cycles");
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({w_busy, w_done, w_fail, w_prime_req, w_mul_start, w_inv_start, w_load} !== 7'b0) begin
            failures++;
            $display("FAIL rmi_async_flags: got %b want 0000000",
                     {w_busy, w_done, w_fail, w_prime_req, w_mul_start, w_inv_start, w_load});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (w_busy !== 1'b0 || w_done !== 1'b0 || w_prime_req !== 1'b0 || n_load != 0) begin
            failures++;
            $display("FAIL rmi_late_done: got busy=%b done=%b req=%b loads=%0d want 0 0 0 0",
                     w_busy, w_done, w_prime_req, n_load);
        end
        checks++;
        if (w_n !== '0 || w_e !== '0 || w_d !== '0) begin
            failures++;
            $display("FAIL rmi_ned_zero: got n=%0d e=%0d d=%0d want 0", w_n, w_e, w_d);
        end
    endtask

    task automatic test_handshake_timing();
        bit to;
        do_reset();
        push_prime(61); push_prime(53); push_prime(17);
        inv_ok_e   = SZ'(17);
        inv_ok_d   = WD'(2753);
        early_mode = 1'b1;
        mul_lat    = 5;
        start_run();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            st = i[0];
        end
        st = 1'b0;
        wait_end(800, to);
        checks++;
        if (to || w_done !== 1'b1) begin
            failures++;
            $display("FAIL hs_done: got timeout=%0d done=%b want 0 1", to, w_done);
        end
        checks++;
        if (w_n !== WD'(3233)) begin
            failures++;
            $display("FAIL hs_n: got %0d want 3233", w_n);
        end
        checks++;
        if (w_d !== WD'(2753) || w_e !== SZ'(17)) begin
            failures++;
            $display("FAIL hs_ed: got e=%0d d=%0d want 17 2753", w_e, w_d);
        end
        checks++;
        if (n_mul != 2 || n_acks != 3 || n_load != 1) begin
            failures++;
            $display("FAIL hs_no_restart: got mul=%0d acks=%0d loads=%0d want 2 3 1",
                     n_mul, n_acks, n_load);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_q_eq_p();
        test_e_reject();
        test_exhaustion();
        test_reset_mid_inv();
        test_handshake_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
